bch_31_encoder: RTL and testbench

BCH_31_ENCODER -- requirements
Module: bch_31_encoder

---
 rtl/bch_31_encoder.sv | 62 ++++++
 tb/tb_bch_31_encoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bch_31_encoder.sv
// bch_31_encoder: bit-serial systematic BCH(31,21) encoder, g(x)=x^10+x^9+x^8+x^6+x^5+x^3+1.
// Define BCH_31_ERR_INJECT_EN to add err_mask, XORed into the codeword for decoder testing.
module bch_31_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [20:0] msg,
`ifdef BCH_31_ERR_INJECT_EN
    input  logic [30:0] err_mask,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [30:0] codeword,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t      r_state, w_next;
    logic [20:0] r_msg;
    logic [9:0]  r_lfsr;
    logic [4:0]  r_cnt;
    logic        w_fb;
    logic        w_accept;
    logic [30:0] w_mask;
    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_fb     = r_msg[r_cnt] ^ r_lfsr[9];
`ifdef BCH_31_ERR_INJECT_EN
    logic [30:0] r_mask;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_mask <= '0;
        else if (w_accept) r_mask <= err_mask;
    assign w_mask = r_mask;
`else
    assign w_mask = '0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        if (w_accept) w_next = SHIFT;
        else if (r_state == SHIFT && r_cnt == 5'd0) w_next = DONE;
        else if (r_state == DONE && out_ready) w_next = IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_msg  <= '0;
            r_lfsr <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_msg  <= msg;
            r_lfsr <= '0;
            r_cnt  <= 5'd20;
        end else if (r_state == SHIFT) begin
            r_lfsr <= {r_lfsr[8:0], 1'b0} ^ (w_fb ? 10'h369 : 10'h000);
            r_cnt  <= (r_cnt == 5'd0) ? 5'd0 : r_cnt - 5'd1;
        end
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign codeword  = out_valid ? ({r_msg, r_lfsr} ^ w_mask) : '0;
endmodule

// File: tb/tb_bch_31_encoder.sv
// tb_bch_31_encoder: directed checks of latency, known codewords, linearity, GF(2^5) syndromes,
// output hold under backpressure and reset abort.
module tb_bch_31_encoder;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [20:0] msg = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [30:0] codeword;
    logic        busy;
`ifdef BCH_31_ERR_INJECT_EN
    logic [30:0] err_mask = '0;
`endif
    int total = 0;
    int bad   = 0;

    bch_31_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .msg(msg),
`ifdef BCH_31_ERR_INJECT_EN
        .err_mask(err_mask),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .codeword(codeword), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // multiply by alpha in GF(2^5), alpha^5 = alpha^2 + 1
    function automatic logic [4:0] mx(input logic [4:0] a);
        return a[4] ? ({a[3:0], 1'b0} ^ 5'h05) : {a[3:0], 1'b0};
    endfunction

    function automatic logic [9:0] synd(input logic [30:0] c);
        logic [4:0] s1 = 0, s3 = 0, p1 = 5'd1, p3 = 5'd1;
        for (int i = 0; i < 31; i++) begin
            if (c[i]) begin
                s1 ^= p1;
                s3 ^= p3;
            end
            p1 = mx(p1);
            p3 = mx(mx(mx(p3)));
        end
        return {s1, s3};
    endfunction

    task automatic start(input logic [20:0] m);
        chk("idle_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1;
        msg = m;
        @(posedge clk); #1;
        in_valid = 0;
        msg = 21'($urandom);
        chk("shift_ready_busy", {30'd0, in_ready, busy}, 32'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, 21);
    endtask

    task automatic ack();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic encode(input logic [20:0] m, output logic [30:0] cw);
        int lat;
        start(m);
        wait_done(lat);
        cw = codeword;
        ack();
    endtask

    initial begin
        logic [30:0] cw, ca, cb, cab, c0;
        logic [20:0] a, b;
        int lat;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_codeword", {1'b0, codeword}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        encode(21'h0, cw);
        chk("cw_zero", {1'b0, cw}, 32'h0);
        chk("after_ack_valid", {31'd0, out_valid}, 32'd0);
        chk("after_ack_codeword", {1'b0, codeword}, 32'd0);
        encode(21'h000001, cw);
        chk("cw_msg1", {1'b0, cw}, 32'h00000769);
        encode(21'h000002, cw);
        chk("cw_msg2", {1'b0, cw}, 32'h000009BB);
        chk("synd_msg2", {22'd0, synd(cw)}, 32'd0);

        for (int n = 0; n < 300; n++) begin
            a = 21'($urandom);
            b = 21'($urandom);
            encode(a, ca);
            encode(b, cb);
            encode(a ^ b, cab);
            chk("linear", {1'b0, ca ^ cb}, {1'b0, cab});
            chk("systematic", {11'd0, cab[30:10]}, {11'd0, a ^ b});
            chk("synd_a", {22'd0, synd(ca)}, 32'd0);
        end

        start(21'h000005);
        wait_done(lat);
        c0 = codeword;
        chk("cw_msg5", {1'b0, c0}, 32'h0000141F);
        for (int n = 0; n < 50; n++) begin
            in_valid = 1'($urandom);
            msg = 21'($urandom);
            @(posedge clk); #1;
            chk("hold_cw", {1'b0, codeword}, {1'b0, c0});
            chk("hold_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
        end
        in_valid = 0;
        ack();
        chk("release_ready", {30'd0, in_ready, out_valid}, 32'd2);

        start(21'h1FFFFF);
        repeat (10) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("abort_valid_busy", {30'd0, out_valid, busy}, 32'd0);
        chk("abort_codeword", {1'b0, codeword}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        encode(21'h000001, cw);
        chk("post_reset_msg1", {1'b0, cw}, 32'h00000769);

`ifdef BCH_31_ERR_INJECT_EN
        err_mask = 31'h40000001;
        encode(21'h000001, cw);
        err_mask = '0;
        chk("inject_cw", {1'b0, cw}, 32'h40000768);
        chk("inject_synd_nonzero", {31'd0, synd(cw) != 10'd0}, 32'd1);
        chk("inject_clean", {1'b0, cw ^ 31'h40000001}, 32'h00000769);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
